// File: rtl/cmp_sched_pkg.sv
// Shared types for the comparator-sharing scheduler.
// Holds the FSM state enum, the sampled-result bundle and the counter width.
package cmp_sched_pkg;

    localparam int DONE_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic err;
    } cmp_result_t;

    // Only the codes 00, 01 and 10 are legal from the comparator.
    // An X/Z bit makes every equality test false, so it falls through to err.
    function automatic cmp_result_t sample_result(
        input logic eq,
        input logic gt
    );
        cmp_result_t r;
        r.eq  = eq;
        r.gt  = gt;
        r.lt  = ~eq & ~gt;
        r.err = 1'b1;
        if (eq == 1'b0 && gt == 1'b0)
            r.err = 1'b0;
        else if (eq == 1'b1 && gt == 1'b0)
            r.err = 1'b0;
        else if (eq == 1'b0 && gt == 1'b1)
            r.err = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/cmp_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set req bit at or after ptr.
// Ports: req, ptr, en in; one-hot grant, grant_idx, any out.
module rr_arbiter #(
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = '0;
        for (int i = 0; i < R; i++) begin
            j = IW'((int'(ptr) + i) % R);
            if (en && !any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = j;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_sched.sv
// Time-shares one external magnitude comparator among R requesters.
// Ports: req_valid/req_a/req_b/req_ready in handshake, cmp_a/cmp_b/cmp_eq/cmp_gt
// to the comparator, rsp_* one-cycle tagged response, busy and done_count status.
module cmp_share_sched
    import cmp_sched_pkg::*;
#(
    parameter  int N             = 8,
    parameter  int R             = 4,
    parameter  int SETTLE_CYCLES = 2,
    localparam int IW            = $clog2(R)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [R-1:0]          req_valid,
    input  logic [R-1:0][N-1:0]   req_a,
    input  logic [R-1:0][N-1:0]   req_b,
    output logic [R-1:0]          req_ready,
    output logic [N-1:0]          cmp_a,
    output logic [N-1:0]          cmp_b,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_eq,
    output logic                  rsp_gt,
    output logic                  rsp_lt,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [DONE_W-1:0]     done_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] id;
    logic [IW-1:0] g_idx;
    logic [R-1:0]  grant;
    logic [CW-1:0] cnt;
    logic          en;
    logic          accept;
    logic          fire;
    cmp_result_t   smp;
    cmp_result_t   res;

    rr_arbiter #(
        .R(R)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (en),
        .grant     (grant),
        .grant_idx (g_idx),
        .any       (accept)
    );

    // Last SETTLE cycle: comparator outputs are captured on this edge.
    assign fire = (state == SETTLE) && (cnt == '0);
    assign smp  = sample_result(cmp_eq, cmp_gt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SETTLE;
            SETTLE:  if (fire)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are masked during reset so every output reads 0 while it is held.
    always_comb begin
        en        = (state == IDLE) && !reset;
        req_ready = grant;
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            id    <= '0;
            cnt   <= '0;
            cmp_a <= '0;
            cmp_b <= '0;
        end else if (accept) begin
            cmp_a <= req_a[g_idx];
            cmp_b <= req_b[g_idx];
            id    <= g_idx;
            cnt   <= CNT_INIT;
            ptr   <= (g_idx == IW'(R - 1)) ? '0 : g_idx + 1'b1;
        end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            res        <= '0;
            done_count <= '0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_id     <= id;
                res        <= smp;
                done_count <= done_count + 1'b1;
            end
        end
    end

    assign rsp_eq  = res.eq;
    assign rsp_gt  = res.gt;
    assign rsp_lt  = res.lt;
    assign rsp_err = res.err;

endmodule

// File: doc/cmp_share_sched.md
# cmp_share_sched

Round-robin scheduler that time-shares one N-bit magnitude comparator (`EQ`/`GT` outputs, combinational, multi-ns settle) among R requesters. It accepts a comparison request over a valid/ready handshake, drives the comparator operands from registers, waits a programmable settle window, then samples `EQ`/`GT` and returns a tagged one-cycle response. It sits between requesting datapath blocks and the shared gate-level comparator instance.

## Interface
- `N`, 8: operand width.
- `R`, 4: number of requesters (2..16).
- `SETTLE_CYCLES`, 2: clock cycles the operands are held before sampling (≥1).
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input R: per-requester request valid.
- `req_a` input R×N: per-requester operand A.
- `req_b` input R×N: per-requester operand B.
- `req_ready` output R: one-hot accept strobe; combinational.
- `cmp_a` output N: registered operand A to the comparator.
- `cmp_b` output N: registered operand B to the comparator.
- `cmp_eq` input 1: comparator `EQ` output.
- `cmp_gt` input 1: comparator `GT` output.
- `rsp_valid` output 1: one-cycle response strobe.
- `rsp_id` output clog2(R): index of the requester being answered.
- `rsp_eq`, `rsp_gt`, `rsp_lt` outputs 1 each: sampled result, where `rsp_lt` = ~eq & ~gt.
- `rsp_err` output 1: `cmp_eq` and `cmp_gt` both 1, or either is X/Z, at sample time.
- `busy` output 1: state is not IDLE.
- `done_count` output 16: completed responses, wraps modulo 2^16.

## Operation
- **States:** IDLE and SETTLE; the state encoding lives in the package.
- **IDLE:** if any `req_valid` is set, the round-robin arbiter picks `g` as the first set bit at or after `ptr`, wrapping. `req_ready[g]` = 1 in the same cycle.
  - On the clock edge: `cmp_a` ← `req_a[g]`, `cmp_b` ← `req_b[g]`, `id` ← `g`, `cnt` ← `SETTLE_CYCLES`−1, `ptr` ← (`g`+1) mod R, state → SETTLE.
- **SETTLE:**
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0: register `cmp_eq`/`cmp_gt` into the `rsp_*` outputs, set `rsp_valid` ← 1 and `rsp_id` ← `id`, increment `done_count`, state → IDLE.
- **`req_ready`:** always 0 outside IDLE.
- **`rsp_valid`:** high for exactly one cycle. It may coincide with a new grant in IDLE. The response path has no backpressure.
- **Requester rule:** `req_valid` and its operands stay stable until `req_ready` is seen. Dropping valid early is illegal; a bench assertion flags it.
- **Operand hold:** `cmp_a`/`cmp_b` hold their value after the response until the next grant. They never change during SETTLE.
- **Single requester:** the same requester is served back-to-back, with no idle gap beyond the protocol.

## Timing
- **Reset values:** every output 0. `ptr` = 0, state = IDLE, `cnt` = 0.
- **Reset mid-SETTLE:** the in-flight request is dropped and no response is issued. The requester's handshake already completed, so the request is lost by design.
- **Latency:** accept in cycle T; `rsp_valid` high in cycle T+SETTLE_CYCLES+1.
- **Throughput:** one comparison per SETTLE_CYCLES+1 cycles.
- **Sampling point:** `cmp_eq`/`cmp_gt` are sampled at the end of the SETTLE cycle with `cnt` = 0. The effective comparator settle budget is SETTLE_CYCLES clock periods minus clock-to-q.
- **Simultaneous requests:** exactly one grant per IDLE cycle. The `ptr` rotation guarantees every valid requester is granted within R grants.
- **Idle with no requests:** `busy` = 0, all outputs hold except `rsp_valid` = 0.

## Structure
- **Package `cmp_sched_pkg`:** state enum (`IDLE`, `SETTLE`), a `cmp_result_t` struct {eq, gt, lt, err}, and the `done_count` width constant.
- **Sub-module `rr_arbiter`:**
  - Parameter R.
  - Inputs: `req[R]`, `ptr`, `en`.
  - Outputs: `grant` (one-hot), `grant_idx`, `any`.
  - Purely combinational; `ptr` is owned by the top level.

## Test plan
- **Basic compare** (R=4, SETTLE_CYCLES=2, N=8): requester 1 sends `a`=8'h5A, `b`=8'h5A. Expect `req_ready[1]` at T and `rsp_valid` at T+3 with `rsp_id`=1, eq=1, gt=0, lt=0.
- **Simultaneous requests:** all four valid with pairs (8'hFF, 8'h00), (8'h00, 8'hFF), (8'h80, 8'h7F), (8'h10, 8'h10). Expect grants in order 0, 1, 2, 3, responses every 3 cycles with gt/lt/gt/eq, and `done_count` = 4.
- **Round-robin fairness:** requesters 0 and 3 held valid continuously. Grants alternate 0, 3, 0, 3, …, with neither starved over 20 grants.
- **Reset mid-operation:** assert `reset` one cycle into SETTLE. Expect all outputs 0 immediately, no `rsp_valid`, and after release a new request to requester 2 is granted first because `ptr` = 0 and only requester 2 is valid.
- **Error flag:** comparator model forces eq=1, gt=1. Expect `rsp_err` = 1 alongside `rsp_valid`, with the other flags as sampled.
- **Exhaustive sweep:** all 65536 (a, b) pairs via requester 0 against a behavioral reference model. Expect zero mismatches and `done_count` wrapped to 0.
